// File: rtl/pp_pkg.sv
// Shared types and defaults for the partial-product row generator.
// Holds the FSM state encoding and the default operand width.
package pp_pkg;

  localparam int PP_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } pp_state_t;

endpackage

// File: rtl/pp_next_one.sv
// Lowest set bit of vec above (or at, when incl) index from.
// none is set when no qualifying bit exists; pos is then 0.
module pp_next_one
  import pp_pkg::*;
#(
  parameter  int WIDTH = PP_WIDTH,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic [IDXW-1:0]  from,
  input  logic             incl,
  output logic [IDXW-1:0]  pos,
  output logic             none
);

  // Scan downward so the lowest qualifying bit wins.
  always_comb begin
    pos  = '0;
    none = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i] && (i > int'(from) ||
          (incl && i == int'(from)))) begin
        pos  = IDXW'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pp_row_gen.sv
// Serial partial-product row generator: one A & b[idx] row per beat.
// Define PP_ZERO_SKIP_EN to emit rows only for set multiplier bits.
module pp_row_gen
  import pp_pkg::*;
#(
  parameter  int WIDTH = PP_WIDTH,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pp,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last
);

  pp_state_t        state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] pp_q;
  logic [IDXW-1:0]  idx_q;
  logic             last_q;

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] nxt_pp;
  logic [IDXW-1:0]  nxt_idx;
  logic             nxt_last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_pp    = pp_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

  // In IDLE the next row is computed from the offered operands.
  assign src_a  = in_ready ? in_a : a_reg;
  assign src_b  = in_ready ? in_b : b_reg;
  assign nxt_pp = src_a & {WIDTH{src_b[nxt_idx]}};

`ifdef PP_ZERO_SKIP_EN
  logic [IDXW-1:0] p_first;
  logic [IDXW-1:0] p_after;
  logic            n_first;
  logic            n_after;

  pp_next_one #(.WIDTH(WIDTH)) u_next (
    .vec  (src_b),
    .from (in_ready ? '0 : idx_q),
    .incl (in_ready),
    .pos  (p_first),
    .none (n_first)
  );

  // Second finder tells whether the chosen row is the final one.
  pp_next_one #(.WIDTH(WIDTH)) u_after (
    .vec  (src_b),
    .from (p_first),
    .incl (1'b0),
    .pos  (p_after),
    .none (n_after)
  );

  assign nxt_idx  = p_first;
  assign nxt_last = n_first | n_after;
`else
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  assign nxt_idx  = in_ready ? '0 : idx_q + IDXW'(1);
  assign nxt_last = (nxt_idx == LAST_IDX);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      pp_q   <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= in_a;
            b_reg  <= in_b;
            pp_q   <= nxt_pp;
            idx_q  <= nxt_idx;
            last_q <= nxt_last;
            state  <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (last_q) begin
              state <= IDLE;
            end else begin
              pp_q   <= nxt_pp;
              idx_q  <= nxt_idx;
              last_q <= nxt_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_row_gen.sv
// Directed bench for pp_row_gen at WIDTH=8, both build variants.
// Expected rows come from hand values and a tiny row model.
module tb_pp_row_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pp;
  logic [2:0] out_idx;
  logic       out_last;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rp[16];
  logic [2:0] ri[16];
  logic       rl[16];
  int         rn;
  int         stab_err;
  bit         col_to;
  bit         send_to;

  logic [7:0] ep[16];
  logic [2:0] ei[16];
  logic       el[16];
  int         en;

  always #5 clk = ~clk;

  pp_row_gen #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pp    (out_pp),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  function automatic void build_exp(input logic [7:0] a,
                                    input logic [7:0] b);
    en = 0;
`ifdef PP_ZERO_SKIP_EN
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        ep[en] = a;
        ei[en] = 3'(i);
        el[en] = 1'b0;
        en++;
      end
    end
    if (en == 0) begin
      ep[0] = 8'h00;
      ei[0] = 3'd0;
      el[0] = 1'b1;
      en    = 1;
    end else begin
      el[en-1] = 1'b1;
    end
`else
    for (int i = 0; i < 8; i++) begin
      ep[i] = b[i] ? a : 8'h00;
      ei[i] = 3'(i);
      el[i] = (i == 7);
    end
    en = 8;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    send_to = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        send_to  = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic collect(input bit toggle);
    logic [7:0] hp;
    logic [2:0] hi;
    logic       hl;
    bit         held;
    bit         ph;
    rn = 0; stab_err = 0; col_to = 1'b1;
    held = 1'b0; ph = 1'b1;
    hp = '0; hi = '0; hl = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (held && (!out_valid || out_pp !== hp ||
          out_idx !== hi || out_last !== hl))
        stab_err++;
      out_ready = toggle ? ph : 1'b1;
      ph   = ~ph;
      held = 1'b0;
      if (out_valid && out_ready) begin
        if (rn < 16) begin
          rp[rn] = out_pp;
          ri[rn] = out_idx;
          rl[rn] = out_last;
        end
        rn++;
        if (out_last) begin
          @(negedge clk);
          out_ready = 1'b0;
          col_to    = 1'b0;
          return;
        end
      end else if (out_valid) begin
        held = 1'b1;
        hp = out_pp; hi = out_idx; hl = out_last;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got rdy=%b vld=%b exp 1 0",
               in_ready, out_valid);
    end
    checks++;
    if (out_pp !== 8'h00 || out_idx !== 3'd0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got pp=%h idx=%0d last=%b exp 0 0 0",
               out_pp, out_idx, out_last);
    end
    checks++;
    if (dut.a_reg !== 8'h00 || dut.b_reg !== 8'h00) begin
      failures++;
      $display("FAIL reset_regs got a=%h b=%h exp 00 00",
               dut.a_reg, dut.b_reg);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send(8'hA5, 8'h03);
    checks++;
    if (send_to || out_valid !== 1'b1 || out_idx !== 3'd0 ||
        in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_lat got to=%b vld=%b idx=%0d rdy=%b exp 0 1 0 0",
               send_to, out_valid, out_idx, in_ready);
    end
    collect(1'b0);
    build_exp(8'hA5, 8'h03);
    checks++;
    if (col_to || rn !== en) begin
      failures++;
      $display("FAIL basic_count got to=%b n=%0d exp 0 %0d",
               col_to, rn, en);
    end
    for (int k = 0; k < en && k < rn; k++) begin
      checks++;
      if ({rp[k], ri[k], rl[k]} !== {ep[k], ei[k], el[k]}) begin
        failures++;
        $display("FAIL basic_row%0d got %h/%0d/%b exp %h/%0d/%b",
                 k, rp[k], ri[k], rl[k], ep[k], ei[k], el[k]);
      end
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got rdy=%b vld=%b exp 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_stall();
    send(8'hA5, 8'h03);
    collect(1'b1);
    build_exp(8'hA5, 8'h03);
    checks++;
    if (col_to || rn !== en || stab_err !== 0) begin
      failures++;
      $display("FAIL stall_count got to=%b n=%0d err=%0d exp 0 %0d 0",
               col_to, rn, stab_err, en);
    end
    for (int k = 0; k < en && k < rn; k++) begin
      checks++;
      if ({rp[k], ri[k], rl[k]} !== {ep[k], ei[k], el[k]}) begin
        failures++;
        $display("FAIL stall_row%0d got %h/%0d/%b exp %h/%0d/%b",
                 k, rp[k], ri[k], rl[k], ep[k], ei[k], el[k]);
      end
    end
  endtask

  task automatic test_zero_skip();
`ifdef PP_ZERO_SKIP_EN
    send(8'hFF, 8'h82);
    collect(1'b0);
    checks++;
    if (col_to || rn !== 2) begin
      failures++;
      $display("FAIL skip_count got to=%b n=%0d exp 0 2", col_to, rn);
    end
    checks++;
    if ({rp[0], ri[0], rl[0], rp[1], ri[1], rl[1]} !==
        {8'hFF, 3'd1, 1'b0, 8'hFF, 3'd7, 1'b1}) begin
      failures++;
      $display("FAIL skip_rows got %h/%0d/%b %h/%0d/%b exp ff/1/0 ff/7/1",
               rp[0], ri[0], rl[0], rp[1], ri[1], rl[1]);
    end
    send(8'hAB, 8'h00);
    collect(1'b0);
    checks++;
    if (col_to || rn !== 1 || {rp[0], ri[0], rl[0]} !==
        {8'h00, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL skip_b0 got n=%0d %h/%0d/%b exp 1 00/0/1",
               rn, rp[0], ri[0], rl[0]);
    end
`else
    send(8'hFF, 8'h00);
    collect(1'b0);
    checks++;
    if (col_to || rn !== 8) begin
      failures++;
      $display("FAIL b0_count got to=%b n=%0d exp 0 8", col_to, rn);
    end
    for (int k = 0; k < 8 && k < rn; k++) begin
      checks++;
      if ({rp[k], ri[k], rl[k]} !== {8'h00, 3'(k), (k == 7)}) begin
        failures++;
        $display("FAIL b0_row%0d got %h/%0d/%b exp 00/%0d/%b",
                 k, rp[k], ri[k], rl[k], k, (k == 7));
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    send(8'h5A, 8'hFF);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd2) begin
      failures++;
      $display("FAIL mid_row2 got vld=%b idx=%0d exp 1 2",
               out_valid, out_idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pp !== 8'h00) begin
      failures++;
      $display("FAIL mid_rst got vld=%b rdy=%b pp=%h exp 0 1 00",
               out_valid, in_ready, out_pp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h01, 8'h01);
    checks++;
    if (send_to || out_valid !== 1'b1 || out_idx !== 3'd0 ||
        out_pp !== 8'h01) begin
      failures++;
      $display("FAIL mid_first got to=%b vld=%b idx=%0d pp=%h exp 0 1 0 01",
               send_to, out_valid, out_idx, out_pp);
    end
    collect(1'b0);
    build_exp(8'h01, 8'h01);
    checks++;
    if (col_to || rn !== en || ri[0] !== 3'd0 || rp[0] !== 8'h01) begin
      failures++;
      $display("FAIL mid_rows got n=%0d %h/%0d exp %0d 01/0",
               rn, rp[0], ri[0], en);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_a = 8'h0F;
    in_b = 8'h80;
    @(negedge clk);
    in_a = 8'h33;
    in_b = 8'h01;
    collect(1'b0);
    build_exp(8'h0F, 8'h80);
    checks++;
    if (col_to || rn !== en) begin
      failures++;
      $display("FAIL b2b_count got to=%b n=%0d exp 0 %0d", col_to, rn, en);
    end
    for (int k = 0; k < en && k < rn; k++) begin
      checks++;
      if ({rp[k], ri[k], rl[k]} !== {ep[k], ei[k], el[k]}) begin
        failures++;
        $display("FAIL b2b_row%0d got %h/%0d/%b exp %h/%0d/%b",
                 k, rp[k], ri[k], rl[k], ep[k], ei[k], el[k]);
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready got %b exp 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_pp !== 8'h33) begin
      failures++;
      $display("FAIL b2b_second got vld=%b idx=%0d pp=%h exp 1 0 33",
               out_valid, out_idx, out_pp);
    end
    collect(1'b0);
    build_exp(8'h33, 8'h01);
    checks++;
    if (col_to || rn !== en || rp[0] !== 8'h33) begin
      failures++;
      $display("FAIL b2b_drain got to=%b n=%0d pp0=%h exp 0 %0d 33",
               col_to, rn, rp[0], en);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_zero_skip();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
